apu_reg_sequencer: RTL

- Timed register-write scheduler for the APU register window $4000-$401F.
- A host (test bench or debug controller) queues commands of the form (register index, data, delay in M2 cycles). The block replays them as write cycles aligned to the APU's M2 phase.
- Lets benches and the debug path program the sound channels with cycle-accurate spacing, without a running 6502 program.

---
 rtl/apu_reg_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/apu_reg_sequencer.sv
// Timed register-write scheduler for the APU window $4000-$401F, replaying queued writes on M2.
// Optional macro APU_SEQ_FLUSH_EN adds a flush input that empties the queue and abandons a pending wait.
module apu_reg_sequencer #(
   parameter int DEPTH   = 8,
   parameter int DELAY_W = 16
) (
   input  logic                         CLK,
   input  logic                         RES,
   input  logic                         M2,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [4:0]                   cmd_addr,
   input  logic [7:0]                   cmd_data,
   input  logic [DELAY_W-1:0]           cmd_delay,
`ifdef APU_SEQ_FLUSH_EN
   input  logic                         flush,
`endif
   output logic [4:0]                   RA,
   output logic [7:0]                   RD,
   output logic                         n_WR,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         done
);

   localparam int CW      = $clog2(DEPTH + 1);
   localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENTRY_W = 5 + 8 + DELAY_W;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WAIT   = 2'd1;
   localparam logic [1:0] STROBE = 2'd2;

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]      r_wrPtr;
   logic [PW-1:0]      r_rdPtr;
   logic [CW-1:0]      r_count;
   logic [1:0]         r_state;
   logic [DELAY_W-1:0] r_cnt;
   logic [4:0]         r_ra;
   logic [7:0]         r_rd;
   logic               r_nWr;
   logic               r_done;
   logic               r_m2Q;

   logic               w_flush;
   logic               w_rise;
   logic               w_fall;
   logic               w_push;
   logic               w_pop;
   logic [ENTRY_W-1:0] w_head;

`ifdef APU_SEQ_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_rise    = M2 & ~r_m2Q;
   assign w_fall    = ~M2 & r_m2Q;
   assign cmd_ready = (r_count != FULL_COUNT);
   assign w_push    = cmd_valid & cmd_ready & ~w_flush;
   assign w_pop     = (r_state == IDLE) && (r_count != '0) && !w_flush;
   assign w_head    = r_mem[r_rdPtr];

   assign RA    = r_ra;
   assign RD    = r_rd;
   assign n_WR  = r_nWr;
   assign done  = r_done;
   assign count = r_count;
   assign busy  = (r_state != IDLE) || (r_count != '0);

   // Storage carries no reset; occupancy and pointers decide what is valid.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= {cmd_addr, cmd_data, cmd_delay};
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Delay D counts down on M2 rises, so the write lands on rise D+1 after the pop.
   always_ff @(posedge CLK) begin
      if (RES) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ra    <= '0;
         r_rd    <= '0;
         r_nWr   <= 1'b1;
         r_done  <= 1'b0;
         r_m2Q   <= 1'b0;
      end else begin
         r_m2Q  <= M2;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_ra    <= w_head[ENTRY_W-1 -: 5];
                  r_rd    <= w_head[DELAY_W+7 -: 8];
                  r_cnt   <= w_head[DELAY_W-1:0];
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_flush) begin
                  r_state <= IDLE;
               end else if (w_rise) begin
                  if (r_cnt == '0) begin
                     r_nWr   <= 1'b0;
                     r_state <= STROBE;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            STROBE: begin
               if (w_fall) begin
                  r_nWr   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_nWr   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
